// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle CPU: fetch/decode/execute sequencing for
// data-processing, load/store and branch(-link) instructions, plus a retired-instruction counter.
module multicycle_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] DATA,
    input  logic        start,
    output logic        PCWrite,
    output logic        MemAdr,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        IRWrite,
    output logic        Opr2,
    output logic        RegDst,
    output logic        MemToReg,
    output logic        ALUSrcA,
    output logic        RegWrite,
    output logic        PCSrc,
    output logic        FlagWrite,
    output logic        Start_Flag,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUOperation,
    output logic [31:0] instr_count
);
    localparam int unsigned CNT_W    = 32;
    localparam logic [2:0]  OP_ADD   = 3'b000;
    localparam logic [2:0]  OP_PASSA = 3'b110;
    localparam logic [2:0]  NOWB_OP  = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_DP_EX, S_DP_WB, S_MA, S_LD_RD,
        S_LD_WB, S_ST_WR, S_BL_SAVE, S_BR, S_BR_LINK
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [1:0] ir_type;
    logic       ir_imm, ir_link, ir_sl;
    logic [2:0] ir_op;
    logic       unused_bits;

    assign ir_type     = DATA[29:28];
    assign ir_imm      = DATA[26];
    assign ir_op       = DATA[25:23];
    assign ir_link     = DATA[24];
    assign ir_sl       = DATA[20];
    assign unused_bits = ^{DATA[31:30], DATA[27], DATA[19:0]};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state logic; BL takes its own branch state so the link write is state-decoded
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (!start) begin
                    state_d = S_FETCH;
                end else begin
                    case (ir_type)
                        2'b00:   state_d = S_DP_EX;
                        2'b01:   state_d = S_MA;
                        2'b10:   state_d = ir_link ? S_BL_SAVE : S_BR;
                        default: state_d = S_FETCH;
                    endcase
                end
            end
            S_DP_EX:   state_d = (ir_op == NOWB_OP) ? S_FETCH : S_DP_WB;
            S_DP_WB:   state_d = S_FETCH;
            S_MA:      state_d = ir_sl ? S_LD_RD : S_ST_WR;
            S_LD_RD:   state_d = S_LD_WB;
            S_LD_WB:   state_d = S_FETCH;
            S_ST_WR:   state_d = S_FETCH;
            S_BL_SAVE: state_d = S_BR_LINK;
            S_BR:      state_d = S_FETCH;
            S_BR_LINK: state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // Output decode; everything held low while reset is asserted
    always_comb begin
        PCWrite      = 1'b0;
        MemAdr       = 1'b0;
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        IRWrite      = 1'b0;
        Opr2         = 1'b0;
        RegDst       = 1'b0;
        MemToReg     = 1'b0;
        ALUSrcA      = 1'b0;
        RegWrite     = 1'b0;
        PCSrc        = 1'b0;
        FlagWrite    = 1'b0;
        Start_Flag   = 1'b0;
        ALUSrcB      = 2'b00;
        ALUOperation = OP_ADD;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    MemAdr   = 1'b1;
                    MemRead  = 1'b1;
                    IRWrite  = 1'b1;
                    ALUSrcA  = 1'b1;
                    ALUSrcB  = 2'b11;
                    PCSrc    = 1'b1;
                    PCWrite  = 1'b1;
                end
                S_DECODE: Start_Flag = 1'b1;
                S_DP_EX: begin
                    ALUSrcB      = ir_imm ? 2'b01 : 2'b00;
                    Opr2         = ~ir_imm;
                    ALUOperation = ir_op;
                    FlagWrite    = ir_sl;
                end
                S_DP_WB, S_LD_WB: begin
                    RegDst   = 1'b1;
                    MemToReg = (state_q == S_LD_WB);
                    RegWrite = 1'b1;
                end
                S_MA, S_LD_RD, S_ST_WR: begin
                    ALUSrcB  = 2'b01;
                    MemRead  = (state_q == S_LD_RD);
                    MemWrite = (state_q == S_ST_WR);
                end
                S_BL_SAVE: begin
                    ALUSrcA      = 1'b1;
                    ALUOperation = OP_PASSA;
                end
                S_BR, S_BR_LINK: begin
                    ALUSrcA  = 1'b1;
                    ALUSrcB  = 2'b10;
                    PCSrc    = 1'b1;
                    PCWrite  = 1'b1;
                    RegWrite = (state_q == S_BR_LINK);
                end
                default: ;
            endcase
        end
    end

    // Retired-instruction counter: bumps on each return to FETCH
    always_comb begin
        count_d = count_q;
        if (state_d == S_FETCH && state_q != S_FETCH) count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign instr_count = rst_n ? count_q : '0;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: table vectors, hand-written corner sequences,
// and randomized instructions checked against an instruction-level latency/effect model.
module tb_multicycle_controller;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] DATA;
    logic        start;
    logic        PCWrite, MemAdr, MemWrite, MemRead, IRWrite, Opr2, RegDst, MemToReg;
    logic        ALUSrcA, RegWrite, PCSrc, FlagWrite, Start_Flag;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUOperation;
    logic [31:0] instr_count;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .DATA(DATA), .start(start),
        .PCWrite(PCWrite), .MemAdr(MemAdr), .MemWrite(MemWrite), .MemRead(MemRead),
        .IRWrite(IRWrite), .Opr2(Opr2), .RegDst(RegDst), .MemToReg(MemToReg),
        .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .PCSrc(PCSrc), .FlagWrite(FlagWrite),
        .Start_Flag(Start_Flag), .ALUSrcB(ALUSrcB), .ALUOperation(ALUOperation),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pcw, madr, mw, mr, irw, opr2, rdst, m2r, asa, rw, pcs, fw, sf;
        logic [1:0] asb;
        logic [2:0] aop;
    } ctl_t;

    typedef struct {
        logic [31:0] d;
        bit          st;
        int          lat, rw, mw, fw, pcw;
    } vec_t;

    ctl_t cur;
    assign cur = {PCWrite, MemAdr, MemWrite, MemRead, IRWrite, Opr2, RegDst, MemToReg,
                  ALUSrcA, RegWrite, PCSrc, FlagWrite, Start_Flag, ALUSrcB, ALUOperation};

    int   checks = 0;
    int   errors = 0;
    ctl_t tr [16];
    int   tr_len;
    int   n_rw, n_mw, n_fw, n_pcw, n_viol;
    vec_t vt [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Instruction-level model: cycles until the next fetch and how many cycles each effect is active
    function automatic void model(input logic [31:0] d, input bit st,
                                  output int lat, output int rw, output int mw,
                                  output int fw, output int pcw);
        lat = 2; rw = 0; mw = 0; fw = 0; pcw = 1;
        if (st) begin
            case (d[29:28])
                2'b00: begin
                    fw = int'(d[20]);
                    if (d[25:23] == 3'b111) lat = 3;
                    else begin lat = 4; rw = 1; end
                end
                2'b01: if (d[20]) begin lat = 5; rw = 1; end
                       else begin lat = 4; mw = 1; end
                2'b10: begin
                    pcw = 2;
                    if (d[24]) begin lat = 4; rw = 1; end
                    else lat = 3;
                end
                default: ;
            endcase
        end
    endfunction

    // Runs one instruction from a FETCH cycle (at negedge) until the next FETCH is seen
    task automatic run_instr(input logic [31:0] d, input bit st);
        tr_len = 0; n_rw = 0; n_mw = 0; n_fw = 0; n_pcw = 0; n_viol = 0;
        DATA = d;
        for (int c = 0; c < 12; c++) begin
            start = (c == 1) ? st : 1'($urandom_range(0, 1));
            #1;
            tr[c] = cur;
            n_rw  += int'(cur.rw);
            n_mw  += int'(cur.mw);
            n_fw  += int'(cur.fw);
            n_pcw += int'(cur.pcw);
            if ((cur.mw && cur.mr) || (cur.pcw && !(cur.irw || cur.asb == 2'b10))) n_viol++;
            @(negedge clk);
            if (cur.irw) begin
                tr_len = c + 1;
                break;
            end
        end
        if (tr_len == 0) check("fetch_timeout", 32'(tr_len), 32'd1);
    endtask

    task automatic run_and_model(input string tag, input logic [31:0] d, input bit st);
        int lat, rw, mw, fw, pcw;
        logic [31:0] cnt0;
        cnt0 = instr_count;
        model(d, st, lat, rw, mw, fw, pcw);
        run_instr(d, st);
        check({tag, "_latency"},  32'(tr_len), 32'(lat));
        check({tag, "_regwrite"}, 32'(n_rw),   32'(rw));
        check({tag, "_memwrite"}, 32'(n_mw),   32'(mw));
        check({tag, "_flagwr"},   32'(n_fw),   32'(fw));
        check({tag, "_pcwrite"},  32'(n_pcw),  32'(pcw));
        check({tag, "_invar"},    32'(n_viol), 32'd0);
        check({tag, "_count"},    instr_count, cnt0 + 32'd1);
    endtask

    initial begin
        logic [4:0] mask;
        logic [31:0] rd;
        vt[0]  = '{32'h0030_3002, 1'b1, 4, 1, 0, 1, 1};
        vt[1]  = '{32'h0390_0000, 1'b1, 3, 0, 0, 1, 1};
        vt[2]  = '{32'h0380_0000, 1'b1, 3, 0, 0, 0, 1};
        vt[3]  = '{32'h0500_0000, 1'b1, 4, 1, 0, 0, 1};
        vt[4]  = '{32'h1010_0000, 1'b1, 5, 1, 0, 0, 1};
        vt[5]  = '{32'h1000_0000, 1'b1, 4, 0, 1, 0, 1};
        vt[6]  = '{32'h2000_0000, 1'b1, 3, 0, 0, 0, 2};
        vt[7]  = '{32'h2100_0000, 1'b1, 4, 1, 0, 0, 2};
        vt[8]  = '{32'h3000_0000, 1'b1, 2, 0, 0, 0, 1};
        vt[9]  = '{32'h1010_0000, 1'b0, 2, 0, 0, 0, 1};
        vt[10] = '{32'h2130_0000, 1'b0, 2, 0, 0, 0, 1};

        rst_n = 1'b0; DATA = '0; start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs_zero", 32'(cur), 32'd0);
        check("rst_count_zero", instr_count, 32'd0);
        rst_n = 1'b1; #1;
        check("post_rst_fetch", 32'(cur.irw), 32'd1);
        check("post_rst_count", instr_count, 32'd0);
        @(negedge clk);
        while (!cur.irw) @(negedge clk);

        // Table vectors
        for (int i = 0; i < 11; i++) begin
            logic [31:0] c0;
            c0 = instr_count;
            run_instr(vt[i].d, vt[i].st);
            check($sformatf("vec%0d_latency", i),  32'(tr_len), 32'(vt[i].lat));
            check($sformatf("vec%0d_regwrite", i), 32'(n_rw),   32'(vt[i].rw));
            check($sformatf("vec%0d_memwrite", i), 32'(n_mw),   32'(vt[i].mw));
            check($sformatf("vec%0d_flagwr", i),   32'(n_fw),   32'(vt[i].fw));
            check($sformatf("vec%0d_pcwrite", i),  32'(n_pcw),  32'(vt[i].pcw));
            check($sformatf("vec%0d_count", i),    instr_count, c0 + 32'd1);
        end

        // DP ADD: execute and writeback cycle contents
        run_instr(32'h0030_3002, 1'b1);
        check("dp_ex_opr2",   32'(tr[2].opr2), 32'd1);
        check("dp_ex_asb",    32'(tr[2].asb),  32'd0);
        check("dp_ex_fw",     32'(tr[2].fw),   32'd1);
        check("dp_wb_rw",     32'(tr[3].rw),   32'd1);
        check("dp_wb_rdst",   32'(tr[3].rdst), 32'd1);
        check("decode_flag",  32'(tr[1].sf),   32'd1);

        // LDR: MemRead only in fetch and read, MemToReg only in writeback
        run_instr(32'h1010_0000, 1'b1);
        for (int c = 0; c < 5; c++) mask[c] = tr[c].mr;
        check("ldr_memread_mask", 32'(mask), 32'h09);
        for (int c = 0; c < 5; c++) mask[c] = tr[c].m2r;
        check("ldr_memtoreg_mask", 32'(mask), 32'h10);

        // STR: single write with data-side address
        run_instr(32'h1000_0000, 1'b1);
        for (int c = 0; c < 4; c++) mask[c] = tr[c].mw;
        mask[4] = 1'b0;
        check("str_memwrite_mask", 32'(mask), 32'h08);
        check("str_memadr", 32'(tr[3].madr), 32'd0);

        // BL: pass-A save, then branch with link write
        run_instr(32'h2100_0000, 1'b1);
        check("bl_save_aop", 32'(tr[2].aop), 32'h6);
        check("bl_save_asa", 32'(tr[2].asa), 32'd1);
        check("bl_br_pcw_rw_rdst", 32'({tr[3].pcw, tr[3].rw, tr[3].rdst}), 32'h6);
        check("bl_br_asb", 32'(tr[3].asb), 32'h2);

        // Counter wrap from all-ones
        DATA = 32'h0030_3002;
        repeat (3) begin start = 1'b1; @(negedge clk); end
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        #1;
        check("wrap_preload", instr_count, 32'hFFFF_FFFF);
        @(negedge clk); #1;
        check("wrap_to_zero", instr_count, 32'd0);
        check("wrap_fetch", 32'(cur.irw), 32'd1);

        // Reset held 3 cycles while in load writeback
        DATA = 32'h1010_0000; start = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("ldwb_reached", 32'({cur.rw, cur.m2r}), 32'h3);
        rst_n = 1'b0; #1;
        check("rst_mid_rw", 32'(cur.rw), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            check($sformatf("rst_hold%0d_outs", c), 32'(cur), 32'd0);
            check($sformatf("rst_hold%0d_cnt", c), instr_count, 32'd0);
        end
        rst_n = 1'b1; #1;
        check("rst_rel_fetch", 32'(cur.irw), 32'd1);
        check("rst_rel_count", instr_count, 32'd0);
        @(negedge clk);
        while (!cur.irw) @(negedge clk);

        // Randomized instruction stream against the model
        for (int i = 0; i < 250; i++) begin
            rd = $urandom;
            run_and_model($sformatf("rnd%0d", i), rd, ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d checks expected completion", checks);
        $fatal(1);
    end
endmodule
